// File: rtl/sync_pkg.sv
// Shared types, default widths and the config check for the sync-pulse sequencer.
package sync_pkg;

   localparam int DEF_CNT_W   = 32;
   localparam int DEF_BURST_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   // A pulse needs at least one high and one low clock; a burst needs at least one pulse.
   function automatic logic cfg_valid(input logic [DEF_CNT_W-1:0]   period,
                                      input logic [DEF_CNT_W-1:0]   high_time,
                                      input logic [DEF_BURST_W-1:0] burst_len,
                                      input logic                   mode_burst);
      return (period >= DEF_CNT_W'(2)) && (high_time != '0) &&
             (high_time < period) && (!mode_burst || (burst_len != '0));
   endfunction

endpackage

// File: rtl/sync_pulse_sequencer_if.sv
// Strobe, config and status bundle between the key/switch side and the sequencer.
interface sync_pulse_sequencer_if #(
   parameter int CNT_W   = sync_pkg::DEF_CNT_W,
   parameter int BURST_W = sync_pkg::DEF_BURST_W
);
   logic               key_start;
   logic               key_stop;
   logic               mode_burst;
   logic [CNT_W-1:0]   period;
   logic [CNT_W-1:0]   high_time;
   logic [BURST_W-1:0] burst_len;
   logic               pulse_out;
   logic               busy;
   logic               done;
   logic               err;
   logic [BURST_W-1:0] pulse_cnt;
   logic [1:0]         state_o;

   modport master (
      output key_start, key_stop, mode_burst, period, high_time, burst_len,
      input  pulse_out, busy, done, err, pulse_cnt, state_o
   );

   modport slave (
      input  key_start, key_stop, mode_burst, period, high_time, burst_len,
      output pulse_out, busy, done, err, pulse_cnt, state_o
   );
endinterface

// File: rtl/sync_pulse_sequencer_key_edge_sync.sv
// Synchronizes an asynchronous key strobe and emits a one-cycle pulse per rising edge.
module key_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLOCK_50,
   input  logic reset_n,
   input  logic key,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // The edge pulse is registered so the controller sees it SYNC_STAGES+1 clocks after the key.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], key};
         prev_q     <= sync_q[SYNC_STAGES-1];
         edge_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/sync_pulse_sequencer.sv
// Arms, runs, bursts and stops a programmable pulse train from start/stop key strobes.
module sync_pulse_sequencer
   import sync_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int BURST_W     = DEF_BURST_W,
   parameter int SYNC_STAGES = 2
) (
   input logic                   CLOCK_50,
   input logic                   reset_n,
   sync_pulse_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   phase_q, phase_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic               pulse_q, pulse_d;
   logic               start_edge, stop_edge, cfg_ok, at_wrap;
   logic [BURST_W:0]   cnt_inc;

   key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .key        (bus.key_start),
      .edge_pulse (start_edge)
   );

   key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .key        (bus.key_stop),
      .edge_pulse (stop_edge)
   );

   assign cfg_ok  = cfg_valid(bus.period, bus.high_time, bus.burst_len, bus.mode_burst);
   assign at_wrap = (phase_q == period_q - ONE);
   assign cnt_inc = {1'b0, cnt_q} + (BURST_W+1)'(1);

   // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      high_d   = high_q;
      burst_d  = burst_q;
      mode_d   = mode_q;

      if (stop_edge) begin
         state_d = IDLE;
         phase_d = '0;
      end else if (start_edge) begin
         phase_d = '0;
         if (cfg_ok) begin
            state_d  = RUN;
            cnt_d    = '0;
            period_d = bus.period;
            high_d   = bus.high_time;
            burst_d  = bus.burst_len;
            mode_d   = bus.mode_burst;
         end else begin
            state_d = ERR;
         end
      end else if (state_q == RUN) begin
         if (at_wrap) begin
            phase_d = '0;
            if (cnt_q != '1) cnt_d = cnt_inc[BURST_W-1:0];
            if (mode_q && (cnt_inc == {1'b0, burst_q})) state_d = DONE;
         end else begin
            phase_d = phase_q + ONE;
         end
      end

      // Decoded from next-state values so the pin moves together with state and phase.
      pulse_d = (state_d == RUN) && (phase_d < high_d);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         high_q   <= '0;
         burst_q  <= '0;
         mode_q   <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         burst_q  <= burst_d;
         mode_q   <= mode_d;
         pulse_q  <= pulse_d;
      end
   end

   assign bus.pulse_out = pulse_q;
   assign bus.pulse_cnt = cnt_q;
   assign bus.state_o   = state_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.err       = (state_q == ERR);

endmodule
